// File: rtl/nz_idx_stream_if.sv
// ---------------------------------------------------------------------------
// nz_idx_stream_if
// Handshake bundle for nz_idx_stream: mask input stream plus index output
// stream.
//   in_valid / in_ready / in_mask       : occupancy mask in (valid/ready)
//   out_valid / out_ready               : output beat handshake
//   out_addr                            : LANES addresses, lane k at
//                                         [k*ADDR_WIDTH +: ADDR_WIDTH]
//   out_lane_valid / out_count          : lane occupancy and its popcount
//   out_last                            : final beat of the current mask
// Modports: master = mask producer / beat consumer, slave = nz_idx_stream.
// ---------------------------------------------------------------------------
interface nz_idx_stream_if #(
    parameter int SPAD_WIDTH = 64,
    parameter int LANES      = 6,
    parameter int ADDR_WIDTH = $clog2(SPAD_WIDTH),
    parameter int CNT_WIDTH  = $clog2(LANES + 1)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SPAD_WIDTH-1:0]       in_mask;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*ADDR_WIDTH-1:0] out_addr;
    logic [LANES-1:0]            out_lane_valid;
    logic [CNT_WIDTH-1:0]        out_count;
    logic                        out_last;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_addr, out_lane_valid, out_count, out_last
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_addr, out_lane_valid, out_count, out_last
    );
endinterface

// File: rtl/nz_idx_stream.sv
// ---------------------------------------------------------------------------
// nz_idx_stream
// Multi-cycle non-zero index extractor. Accepts an occupancy mask and emits
// the positions of its set bits, up to LANES per beat, lowest index first,
// until the mask is exhausted. A zero mask still produces one empty beat
// with out_last=1.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : nz_idx_stream_if.slave (mask in, index beats out)
//   busy    : a mask is held (RUN)
// ---------------------------------------------------------------------------
module nz_idx_stream #(
    parameter int SPAD_WIDTH = 64,
    parameter int LANES      = 6,
    parameter int ADDR_WIDTH = $clog2(SPAD_WIDTH),
    parameter int CNT_WIDTH  = $clog2(LANES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    nz_idx_stream_if.slave    bus,
    output logic              busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                      state;
    logic [SPAD_WIDTH-1:0]       residual;
    logic [LANES*ADDR_WIDTH-1:0] addr_q;
    logic [LANES-1:0]            lane_q;
    logic [CNT_WIDTH-1:0]        count_q;
    logic                        last_q;

    logic                        out_hs;
    logic                        accept;
    logic                        load;
    logic [SPAD_WIDTH-1:0]       src_mask;
    logic [SPAD_WIDTH-1:0]       rest_mask;
    logic [LANES*ADDR_WIDTH-1:0] nxt_addr;
    logic [LANES-1:0]            nxt_lane;
    logic [CNT_WIDTH-1:0]        nxt_count;

    assign bus.out_valid      = (state == RUN);
    assign bus.out_addr       = addr_q;
    assign bus.out_lane_valid = lane_q;
    assign bus.out_count      = count_q;
    assign bus.out_last       = last_q;
    assign busy               = (state == RUN);

    assign out_hs       = bus.out_valid && bus.out_ready;
    // A mask can enter while idle or on the handshake of the last beat,
    // which gives back-to-back masks without a bubble.
    assign bus.in_ready = reset_n && ((state == IDLE) || (out_hs && last_q));
    assign accept       = bus.in_valid && bus.in_ready;
    // A new beat is built either from a freshly accepted mask or from the
    // residual after a non-final beat is consumed.
    assign load         = accept || (out_hs && !last_q);
    assign src_mask     = accept ? bus.in_mask : residual;

    // Chain of find-lowest-set-bit-and-clear stages; stage k sees the mask
    // with the k lower set bits already removed by the stages before it.
    for (genvar k = 0; k < LANES; k++) begin : g_stage
        logic [SPAD_WIDTH-1:0] m_in;
        logic [SPAD_WIDTH-1:0] onehot;
        logic [SPAD_WIDTH-1:0] m_out;
        logic [ADDR_WIDTH-1:0] idx;

        if (k == 0) begin : g_first
            assign m_in = src_mask;
        end else begin : g_next
            assign m_in = g_stage[k-1].m_out;
        end

        // Two's-complement trick isolates the lowest set bit.
        assign onehot = m_in & (-m_in);
        assign m_out  = m_in & ~onehot;

        // NOTE: every variable written in always_comb gets a default first,
        // otherwise the missing path infers a latch.
        always_comb begin
            idx = '0;
            for (int b = 0; b < SPAD_WIDTH; b++) begin
                if (onehot[b]) idx = idx | b[ADDR_WIDTH-1:0];
            end
        end

        // Empty lanes carry address 0 because onehot is 0 there.
        assign nxt_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = idx;
        assign nxt_lane[k]                          = |m_in;
    end

    assign rest_mask = g_stage[LANES-1].m_out;

    always_comb begin
        nxt_count = '0;
        for (int k = 0; k < LANES; k++) begin
            nxt_count = nxt_count + CNT_WIDTH'(nxt_lane[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            residual <= '0;
            addr_q   <= '0;
            lane_q   <= '0;
            count_q  <= '0;
            last_q   <= 1'b0;
        end else if (load) begin
            state    <= RUN;
            residual <= rest_mask;
            addr_q   <= nxt_addr;
            lane_q   <= nxt_lane;
            count_q  <= nxt_count;
            last_q   <= (rest_mask == '0);
        end else if (out_hs) begin
            // Last beat consumed with no new mask waiting.
            state    <= IDLE;
        end
    end
endmodule
